// File: rtl/spi_inemo4.sv
// SPI mode-0 slave model of an iNEMO-style yaw-rate sensor: 16-bit frames, a small
// register map, and a periodic yaw snapshot that raises INT until YAW_H is read.
module spi_inemo4 #(
   parameter int         INT_PERIOD   = 2048,
   parameter logic [7:0] WHO_AM_I_VAL = 8'h6A
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        INT,
   input  logic [15:0] YAW
);

   localparam logic [6:0] ADDR_INT_CTRL = 7'h0D;
   localparam logic [6:0] ADDR_WHO_AM_I = 7'h0F;
   localparam logic [6:0] ADDR_YAW_L    = 7'h26;
   localparam logic [6:0] ADDR_YAW_H    = 7'h27;
   localparam int         CNT_W         = $clog2(INT_PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INT_PERIOD - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

   state_t           state, state_nxt;
   logic [1:0]       ss_sync, sclk_sync, mosi_sync;
   logic             ss_d, sclk_d;
   logic             ss_s, mosi_s, sclk_rise, sclk_fall, ss_fall;
   logic             frame_start, shifting, frame_end;
   logic [3:0]       bit_cnt;
   logic [6:0]       shift_in;
   logic [7:0]       frame_byte, shift_out, rd_data;
   logic             cmd_rd, miso_r;
   logic [6:0]       cmd_addr;
   logic [7:0]       int_ctrl;
   logic [15:0]      snapshot;
   logic [CNT_W-1:0] cnt;
   logic             pending, int_r;
   logic             int_en, tick, apply, wr_commit, int_clr;

   // Sync flops reset low so a slave select still held low after reset never looks like a new frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_sync   <= 2'b00;
         sclk_sync <= 2'b00;
         mosi_sync <= 2'b00;
         ss_d      <= 1'b0;
         sclk_d    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbour.
         ss_sync   <= {ss_sync[0], SS_n};
         sclk_sync <= {sclk_sync[0], SCLK};
         mosi_sync <= {mosi_sync[0], MOSI};
         ss_d      <= ss_sync[1];
         sclk_d    <= sclk_sync[1];
      end
   end

   assign ss_s       = ss_sync[1];
   assign mosi_s     = mosi_sync[1];
   assign sclk_rise  = sclk_sync[1] & ~sclk_d;
   assign sclk_fall  = ~sclk_sync[1] & sclk_d;
   assign ss_fall    = ss_d & ~ss_s;
   assign frame_byte = {shift_in, mosi_s};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      // NOTE: default first so no path through the case leaves the signal unassigned (no latch).
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (ss_fall) state_nxt = ST_SHIFT;
         ST_SHIFT: if (ss_s) state_nxt = ST_IDLE;
                   else if (sclk_rise && bit_cnt == 4'd15) state_nxt = ST_DONE;
         ST_DONE:  if (ss_s) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      frame_start = 1'b0;
      shifting    = 1'b0;
      frame_end   = 1'b0;
      unique case (state)
         ST_IDLE:  frame_start = ss_fall;
         ST_SHIFT: shifting    = ~ss_s;
         ST_DONE:  frame_end   = ss_s;
         default:  ;
      endcase
   end

   always_comb begin
      rd_data = 8'h00;
      case (frame_byte[6:0])
         ADDR_WHO_AM_I: rd_data = WHO_AM_I_VAL;
         ADDR_INT_CTRL: rd_data = int_ctrl;
         ADDR_YAW_L:    rd_data = snapshot[7:0];
         ADDR_YAW_H:    rd_data = snapshot[15:8];
         default:       rd_data = 8'h00;
      endcase
   end

   // frame_byte is the command on the 8th rising edge and the write data on the 16th.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt   <= 4'd0;
         shift_in  <= 7'd0;
         cmd_rd    <= 1'b0;
         cmd_addr  <= 7'd0;
         shift_out <= 8'h00;
         miso_r    <= 1'b0;
      end else if (frame_start) begin
         bit_cnt   <= 4'd0;
         shift_in  <= 7'd0;
         cmd_rd    <= 1'b0;
         cmd_addr  <= 7'd0;
         shift_out <= 8'h00;
         miso_r    <= 1'b0;
      end else if (shifting) begin
         if (sclk_rise) begin
            bit_cnt  <= bit_cnt + 4'd1;
            shift_in <= frame_byte[6:0];
            if (bit_cnt == 4'd7) begin
               cmd_rd    <= frame_byte[7];
               cmd_addr  <= frame_byte[6:0];
               shift_out <= frame_byte[7] ? rd_data : 8'h00;
            end
         end else if (sclk_fall && cmd_rd) begin
            miso_r    <= shift_out[7];
            shift_out <= {shift_out[6:0], 1'b0};
         end
      end else if (state == ST_IDLE) begin
         miso_r <= 1'b0;
      end
   end

   assign wr_commit = shifting & sclk_rise & (bit_cnt == 4'd15) & ~cmd_rd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                          int_ctrl <= 8'h00;
      else if (wr_commit && cmd_addr == ADDR_INT_CTRL)  int_ctrl <= frame_byte;
   end

   assign int_en  = int_ctrl[1];
   assign tick    = int_en & (cnt == CNT_LAST);
   assign apply   = (tick | pending) & ss_s;
   assign int_clr = frame_end & cmd_rd & (cmd_addr == ADDR_YAW_H);

   // A tick never touches the snapshot mid-frame; it waits until slave select is released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         pending  <= 1'b0;
         int_r    <= 1'b0;
         snapshot <= 16'h0000;
      end else if (!int_en) begin
         cnt     <= '0;
         pending <= 1'b0;
         int_r   <= 1'b0;
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (apply) begin
            snapshot <= YAW;
            int_r    <= 1'b1;
            pending  <= 1'b0;
         end else begin
            if (tick)    pending <= 1'b1;
            if (int_clr) int_r   <= 1'b0;
         end
      end
   end

   assign MISO = miso_r;
   assign INT  = int_r;

endmodule

// File: tb/tb_spi_inemo4.sv
// Directed bench for spi_inemo4: bit-banged SPI frames, random yaw/register data, and a
// phase-aware model of when snapshots and INT must appear.
`timescale 1ns/1ps
module tb_spi_inemo4;

   localparam int         P    = 600;
   localparam int         HALF = 10;
   localparam logic [7:0] WHO  = 8'h6A;

   logic        clk = 1'b0;
   logic        rst, SS_n, SCLK, MOSI, MISO, INT;
   logic [15:0] YAW;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int t0 = 0;
   int t16 = 0;

   logic [15:0] exp_snap;
   logic [7:0]  exp_ctrl;
   logic        exp_int;

   spi_inemo4 #(.INT_PERIOD(P), .WHO_AM_I_VAL(WHO)) dut (
      .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
      .MISO(MISO), .INT(INT), .YAW(YAW)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Mode 0: MOSI set while SCLK is low, MISO sampled just before each rising edge.
   task automatic spi_frame(input logic [15:0] word, input int n_edges,
                            output logic [7:0] rd, output logic cmd_miso);
      logic [15:0] sh;
      sh = word;
      rd = 8'h00;
      cmd_miso = 1'b0;
      @(negedge clk);
      SS_n = 1'b0;
      for (int i = 0; i < n_edges; i++) begin
         MOSI = sh[15];
         sh   = {sh[14:0], 1'b0};
         repeat (HALF) @(negedge clk);
         if (i < 8) cmd_miso = cmd_miso | MISO;
         else       rd = {rd[6:0], MISO};
         SCLK = 1'b1;
         if (i == 15) t16 = cyc;
         repeat (HALF) @(negedge clk);
         SCLK = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      SS_n = 1'b1;
      MOSI = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic spi_read(input logic [6:0] addr, output logic [7:0] rd);
      logic cm;
      spi_frame({1'b1, addr, 8'h00}, 16, rd, cm);
      check("miso_low_in_cmd_byte", 16'(cm), 16'd0);
   endtask

   task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
      logic [7:0] rd;
      logic       cm;
      spi_frame({1'b0, addr, data}, 16, rd, cm);
   endtask

   task automatic wait_phase(input int ph);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((((cyc - t0) % P) != ph) && n < 2 * P);
   endtask

   task automatic wait_int(input int limit, output int waited);
      waited = 0;
      while (INT !== 1'b1 && waited < limit) begin
         @(negedge clk);
         waited++;
      end
   endtask

   initial begin
      repeat (95000) @(negedge clk);
      $display("FAIL watchdog: cycle budget exhausted");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd;
      logic       cm;
      logic       seen;
      logic [6:0] a;
      logic [7:0] d;
      int         waited;

      rst = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0; YAW = 16'($urandom);
      exp_snap = 16'h0000; exp_ctrl = 8'h00; exp_int = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_int", 16'(INT), 16'd0);
      check("reset_miso", 16'(MISO), 16'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      spi_read(7'h0F, rd);
      check("who_am_i", 16'(rd), 16'(WHO));
      check("who_am_i_int", 16'(INT), 16'd0);
      check("miso_idle", 16'(MISO), 16'd0);
      spi_read(7'h0D, rd);
      check("int_ctrl_reset", 16'(rd), 16'h00);

      seen = 1'b0;
      repeat (10 * P) begin
         @(negedge clk);
         seen = seen | INT;
      end
      check("no_int_when_disabled", 16'(seen), 16'd0);
      spi_read(7'h26, rd);
      check("yaw_l_reset", 16'(rd), 16'h00);
      spi_read(7'h27, rd);
      check("yaw_h_reset", 16'(rd), 16'h00);

      for (int k = 0; k < 3; k++) begin
         a = 7'($urandom);
         if (a == 7'h0D || a == 7'h0F || a == 7'h26 || a == 7'h27) a = a ^ 7'h40;
         d = 8'($urandom);
         spi_write(a, d);
         spi_read(a, rd);
         check("unmapped_reads_zero", 16'(rd), 16'h00);
      end
      spi_write(7'h0F, 8'($urandom));
      spi_write(7'h26, 8'($urandom));
      spi_write(7'h27, 8'($urandom));
      spi_read(7'h0F, rd);
      check("who_am_i_read_only", 16'(rd), 16'(WHO));
      spi_read(7'h26, rd);
      check("yaw_l_read_only", 16'(rd), 16'h00);
      spi_read(7'h27, rd);
      check("yaw_h_read_only", 16'(rd), 16'h00);

      YAW = 16'hF3A5;
      exp_ctrl = 8'($urandom) | 8'h02;
      spi_write(7'h0D, exp_ctrl);
      wait_int(P + 50, waited);
      check("int_rise_in_time", 16'(INT), 16'd1);
      check("int_latency_window", 16'((cyc - t16 >= P) && (cyc - t16 <= P + 6)), 16'd1);
      t0 = cyc; exp_snap = YAW; exp_int = 1'b1;

      wait_phase(20);
      spi_read(7'h0D, rd);
      check("int_ctrl_readback", 16'(rd), 16'(exp_ctrl));
      wait_phase(20);
      spi_read(7'h26, rd);
      check("yaw_l_first", 16'(rd), 16'(exp_snap[7:0]));
      check("int_kept_by_yaw_l", 16'(INT), 16'(exp_int));
      wait_phase(20);
      spi_read(7'h27, rd);
      exp_int = 1'b0;
      check("yaw_h_first", 16'(rd), 16'(exp_snap[15:8]));
      check("int_cleared_by_yaw_h", 16'(INT), 16'(exp_int));

      wait_phase(P - 5);
      check("int_low_before_tick", 16'(INT), 16'd0);
      wait_phase(3);
      check("int_high_after_period", 16'(INT), 16'd1);

      for (int k = 0; k < 3; k++) begin
         wait_phase(400);
         YAW = 16'($urandom);
         exp_snap = YAW;
         wait_phase(20);
         spi_read(7'h26, rd);
         check("yaw_l_random", 16'(rd), 16'(exp_snap[7:0]));
         check("int_after_yaw_l", 16'(INT), 16'd1);
         wait_phase(20);
         spi_read(7'h27, rd);
         check("yaw_h_random", 16'(rd), 16'(exp_snap[15:8]));
         check("int_after_yaw_h", 16'(INT), 16'd0);
      end

      wait_phase(400);
      YAW = 16'h1234;
      exp_snap = YAW;
      wait_phase(450);
      fork
         spi_frame(16'h8F00, 16, rd, cm);
         begin
            wait_phase(20);
            check("tick_deferred_while_selected", 16'(INT), 16'd0);
         end
      join
      check("who_am_i_across_tick", 16'(rd), 16'(WHO));
      check("deferred_tick_applied", 16'(INT), 16'd1);
      spi_read(7'h26, rd);
      check("yaw_l_deferred", 16'(rd), 16'h34);
      wait_phase(20);
      spi_read(7'h27, rd);
      check("yaw_h_deferred", 16'(rd), 16'h12);
      check("int_cleared_deferred", 16'(INT), 16'd0);

      wait_phase(20);
      check("int_set_before_abort", 16'(INT), 16'd1);
      spi_frame(16'hA700, 12, rd, cm);
      check("abort_read_keeps_int", 16'(INT), 16'd1);
      check("abort_read_miso_low", 16'(MISO), 16'd0);
      wait_phase(20);
      spi_frame(16'h0D00, 12, rd, cm);
      check("abort_write_keeps_int", 16'(INT), 16'd1);
      wait_phase(20);
      spi_read(7'h0D, rd);
      check("abort_write_keeps_ctrl", 16'(rd), 16'(exp_ctrl));

      wait_phase(20);
      spi_write(7'h0D, 8'h00);
      exp_ctrl = 8'h00;
      check("disable_clears_int", 16'(INT), 16'd0);
      seen = 1'b0;
      repeat (2 * P) begin
         @(negedge clk);
         seen = seen | INT;
      end
      check("no_int_after_disable", 16'(seen), 16'd0);
      spi_read(7'h0D, rd);
      check("int_ctrl_disabled", 16'(rd), 16'(exp_ctrl));
      spi_read(7'h26, rd);
      check("snapshot_kept_on_disable", 16'(rd), 16'(exp_snap[7:0]));

      YAW = 16'($urandom);
      spi_write(7'h0D, 8'h02);
      wait_int(P + 50, waited);
      check("int_before_reset", 16'(INT), 16'd1);
      fork
         spi_frame(16'h8F00, 16, rd, cm);
         begin
            repeat (150) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("mid_frame_rst_int", 16'(INT), 16'd0);
            check("mid_frame_rst_miso", 16'(MISO), 16'd0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
         end
      join
      check("frame_ignored_after_reset", 16'(rd), 16'h00);
      fork
         spi_frame(16'h0D02, 16, rd, cm);
         begin
            repeat (40) @(negedge clk);
            rst = 1'b1;
            repeat (3) @(negedge clk);
            rst = 1'b0;
         end
      join
      spi_read(7'h0D, rd);
      check("int_ctrl_after_reset", 16'(rd), 16'h00);
      spi_read(7'h0F, rd);
      check("who_am_i_after_reset", 16'(rd), 16'(WHO));
      spi_read(7'h26, rd);
      check("snapshot_after_reset", 16'(rd), 16'h00);
      check("int_after_reset", 16'(INT), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
